// File: rtl/fp_pkg.sv
// fp_pkg: shared binary32 widths, constants, unpacked operand type and divider FSM states
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W:0] mant;
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp32_t;
  typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_DIV, S_ROUND} div_state_t;
endpackage

// File: rtl/fp32_unpack.sv
// fp32_unpack: split a binary32 into sign/exponent/significand and classify it
module fp32_unpack
  import fp_pkg::*;
(
  input  logic [31:0] x,
  output fp32_t       u
);
  logic exp_zero, exp_ones, frac_zero;
  always_comb begin
    exp_zero = x[30:23] == '0;
    exp_ones = x[30:23] == '1;
    frac_zero = x[22:0] == '0;
    u.sign = x[31];
    u.exp = x[30:23];
    // subnormals are flushed, so a zero exponent field means zero
    u.mant = exp_zero ? '0 : {1'b1, x[22:0]};
    u.is_zero = exp_zero;
    u.is_inf = exp_ones && frac_zero;
    u.is_nan = exp_ones && !frac_zero;
  end
endmodule

// File: rtl/fp32_divider.sv
// fp32_divider: sequential binary32 divider, restoring mantissa division one quotient bit per clock
module fp32_divider
  import fp_pkg::*;
#(
  parameter int ITER_BITS = 26
) (
  input  logic        int_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        busy,
  output logic        done
);
  localparam int CW = $clog2(ITER_BITS + 1);
  div_state_t state, state_nx;
  logic [31:0] a_q, b_q, spec_val_q, spec_val_c, res_c;
  fp32_t ua, ub;
  logic sign_q, spec_q, shift, nan_c, inf_c, zero_c, ge, up, carry;
  logic signed [9:0] exp_q, exp_c, exp_r;
  logic [24:0] rem_q, sum;
  logic [23:0] mb_q, diff, mant;
  logic [22:0] frac;
  logic [ITER_BITS-1:0] q_q;
  logic [CW-1:0] cnt_q;

  fp32_unpack u_ua (.x(a_q), .u(ua));
  fp32_unpack u_ub (.x(b_q), .u(ub));

  assign busy = state != S_IDLE;

  always_comb begin
    state_nx = state;
    state_nx = state == S_IDLE ? (start ? S_UNPACK : S_IDLE) :
               state == S_UNPACK ? S_DIV :
               state == S_DIV ? (cnt_q == CW'(ITER_BITS - 1) ? S_ROUND : S_DIV) : S_IDLE;
  end

  always_comb begin
    shift = ua.mant < ub.mant;
    exp_c = {2'b00, ua.exp} - {2'b00, ub.exp} + 10'd127 - {9'd0, shift};
    nan_c = ua.is_nan || ub.is_nan || (ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf);
    inf_c = ua.is_inf || ub.is_zero;
    zero_c = ub.is_inf || ua.is_zero;
    spec_val_c = nan_c ? QNAN : inf_c ? (POS_INF | {ua.sign ^ ub.sign, 31'h0}) : {ua.sign ^ ub.sign, 31'h0};
  end

  always_comb begin
    ge = rem_q >= {1'b0, mb_q};
    diff = ge ? 24'(rem_q - {1'b0, mb_q}) : rem_q[23:0];
  end

  // the quotient's extra two low bits are guard and round; the final remainder supplies sticky
  always_comb begin
    mant = q_q[ITER_BITS-1 -: 24];
    up = q_q[ITER_BITS-25] && (q_q[ITER_BITS-26] || rem_q != '0 || mant[0]);
    sum = {1'b0, mant} + {24'd0, up};
    carry = sum[24];
    frac = carry ? sum[23:1] : sum[22:0];
    exp_r = exp_q + {9'd0, carry};
    res_c = exp_r >= 10'sd255 ? {sign_q, 8'hFF, 23'h0} :
            exp_r <= 10'sd0 ? {sign_q, 31'h0} : {sign_q, exp_r[7:0], frac};
  end

  always_ff @(posedge int_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      out <= '0;
      done <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      sign_q <= 1'b0;
      exp_q <= '0;
      rem_q <= '0;
      mb_q <= '0;
      q_q <= '0;
      cnt_q <= '0;
      spec_q <= 1'b0;
      spec_val_q <= '0;
    end else begin
      state <= state_nx;
      done <= state == S_ROUND;
      if (state == S_IDLE && start) begin
        a_q <= a;
        b_q <= b;
      end
      if (state == S_UNPACK) begin
        sign_q <= ua.sign ^ ub.sign;
        exp_q <= exp_c;
        rem_q <= shift ? {ua.mant, 1'b0} : {1'b0, ua.mant};
        mb_q <= ub.mant;
        q_q <= '0;
        cnt_q <= '0;
        spec_q <= nan_c || inf_c || zero_c;
        spec_val_q <= spec_val_c;
      end
      if (state == S_DIV) begin
        rem_q <= {diff, 1'b0};
        q_q <= {q_q[ITER_BITS-2:0], ge};
        cnt_q <= cnt_q + CW'(1);
      end
      if (state == S_ROUND) out <= spec_q ? spec_val_q : res_c;
    end
  end
endmodule

// File: tb/tb_fp32_divider.sv
// tb_fp32_divider: directed and randomized checks of fp32_divider against an arithmetic reference
module tb_fp32_divider;
  logic int_clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] out;
  logic busy, done;
  int nvec = 0, nerr = 0;

  fp32_divider dut (.int_clk(int_clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
                    .out(out), .busy(busy), .done(done));

  always #5 int_clk = ~int_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic s, xz, yz, xi, yi, xn, yn;
    int ex, ey, e;
    longint mx, my, q, rm, m;
    s = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = ex == 0;
    yz = ey == 0;
    xi = ex == 255 && x[22:0] == 0;
    yi = ey == 255 && y[22:0] == 0;
    xn = ex == 255 && x[22:0] != 0;
    yn = ey == 255 && y[22:0] != 0;
    if (xn || yn || (xz && yz) || (xi && yi)) return 32'h7FC00000;
    if (xi || yz) return {s, 8'hFF, 23'h0};
    if (yi || xz) return {s, 31'h0};
    mx = longint'({1'b1, x[22:0]});
    my = longint'({1'b1, y[22:0]});
    e = ex - ey + 127;
    if (mx < my) begin
      mx = mx * 2;
      e = e - 1;
    end
    q = (mx << 25) / my;
    rm = (mx << 25) % my;
    m = q >> 2;
    if (((q >> 1) & 1) == 1 && ((q & 1) == 1 || rm != 0 || (m & 1) == 1)) m = m + 1;
    if (m == (longint'(1) << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), 23'(m)};
  endfunction

  task automatic do_div(input logic [31:0] x, input logic [31:0] y, input logic [31:0] expv,
                        input string tag, input bit b2b);
    int n;
    if (!b2b) @(negedge int_clk);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge int_clk);
    #1 start = 1'b0;
    n = 0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && n < 40) begin
      @(posedge int_clk);
      #1 n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd28);
    check(tag, out, expv);
  endtask

  function automatic logic [31:0] rnd_fp();
    int k;
    k = int'($urandom_range(0, 19));
    if (k == 0) return 32'h00000000;
    if (k == 1) return 32'h7F800000;
    if (k == 2) return 32'h7FC00001;
    if (k == 3) return $urandom;
    return {1'($urandom), 8'($urandom_range(90, 164)), 23'($urandom)};
  endfunction

  initial begin
    int n;
    bit seen;
    logic [31:0] x, y;
    #2;
    check("rst_out", out, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge int_clk);
    rst_n = 1'b1;
    do_div(32'h41000000, 32'h40000000, 32'h40800000, "8_2", 1'b0);
    do_div(32'h41000000, 32'h3F800000, 32'h41000000, "8_1", 1'b0);
    do_div(32'h42C80000, 32'h3F800000, 32'h42C80000, "100_1", 1'b0);
    do_div(32'h41000000, 32'hC0000000, 32'hC0800000, "8_m2", 1'b0);
    do_div(32'hC1000000, 32'hC0000000, 32'h40800000, "m8_m2", 1'b0);
    do_div(32'hC15C0000, 32'hC0B00000, 32'h40200000, "m1375_m55", 1'b0);
    do_div(32'h415C0000, 32'hC0B00000, 32'hC0200000, "1375_m55", 1'b0);
    do_div(32'h415C0000, 32'h40B00000, 32'h40200000, "1375_55", 1'b0);
    do_div(32'h415C0000, 32'h3F800000, 32'h415C0000, "1375_1", 1'b0);
    do_div(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "1_3", 1'b0);
    do_div(32'h3F800000, 32'h00000000, 32'h7F800000, "1_0", 1'b0);
    do_div(32'hBF800000, 32'h00000000, 32'hFF800000, "m1_0", 1'b0);
    do_div(32'h00000000, 32'h00000000, 32'h7FC00000, "0_0", 1'b0);
    do_div(32'h7F800000, 32'h7F800000, 32'h7FC00000, "inf_inf", 1'b0);
    do_div(32'h3F800000, 32'h7F800000, 32'h00000000, "1_inf", 1'b0);
    do_div(32'h7F000000, 32'h3E800000, 32'h7F800000, "ovf", 1'b0);
    do_div(32'h00800000, 32'h40000000, 32'h00000000, "unf", 1'b0);
    check("done_cycle", 32'(done), 32'd1);
    do_div(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, "b2b", 1'b1);
    // a second start while busy must not disturb the first division
    @(negedge int_clk);
    a = 32'h41000000;
    b = 32'h40000000;
    start = 1'b1;
    @(posedge int_clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge int_clk);
      #1 n++;
      if (n == 5) begin
        a = 32'h3F800000;
        b = 32'h40400000;
        start = 1'b1;
      end
      if (n == 6) start = 1'b0;
    end
    check("ign_lat", 32'(n), 32'd28);
    check("ign_out", out, 32'h40800000);
    @(posedge int_clk);
    #1 check("ign_idle", 32'(busy), 32'd0);
    // asynchronous reset in the middle of the iteration aborts it
    @(negedge int_clk);
    a = 32'h3F800000;
    b = 32'h40400000;
    start = 1'b1;
    @(posedge int_clk);
    #1 start = 1'b0;
    repeat (11) @(posedge int_clk);
    @(negedge int_clk);
    rst_n = 1'b0;
    #1;
    check("abort_out", out, 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge int_clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge int_clk);
      #1 if (done) seen = 1'b1;
    end
    check("abort_nodone", 32'(seen), 32'd0);
    for (int i = 0; i < 150; i++) begin
      x = rnd_fp();
      y = rnd_fp();
      do_div(x, y, ref_div(x, y), $sformatf("rnd%0d_%h_%h", i, x, y), 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
